// File: rtl/comparator_pkg.sv
// Shared result encoding for the registered magnitude comparator.
// Flags are packed {Equal, Bigger, Lower}; exactly one bit is set for any valid result.
package comparator_pkg;

    typedef logic [2:0] res_t;

    localparam res_t RES_EQ   = 3'b100;
    localparam res_t RES_GT   = 3'b010;
    localparam res_t RES_LT   = 3'b001;
    localparam res_t RES_NONE = 3'b000;

    function automatic res_t pack_flags(input logic eq, input logic gt, input logic lt);
        return {eq, gt, lt};
    endfunction

endpackage

// File: rtl/comparator_slice.sv
// One bit of an MSB-first compare cascade: purely combinational, no state.
// The first differing bit from the top decides; lower bits only matter while still equal.
module comparator_slice
    import comparator_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_gt,
    input  logic i_lt,
    input  logic i_eq,
    output logic o_gt,
    output logic o_lt,
    output logic o_eq
);

    logic w_bit_gt;
    logic w_bit_lt;

    assign w_bit_gt = i_a & ~i_b;
    assign w_bit_lt = ~i_a & i_b;

    always_comb begin
        o_gt = i_gt;
        o_lt = i_lt;
        o_eq = 1'b0;
        if (i_eq) begin
            o_gt = w_bit_gt;
            o_lt = w_bit_lt;
            o_eq = ~(w_bit_gt | w_bit_lt);
        end
    end

endmodule

// File: rtl/comparator_4bit.sv
// Registered A/B magnitude comparator, 1-cycle latency, unsigned or two's-complement.
// No backpressure: every in_valid cycle yields one result with out_valid the cycle after.
module comparator_4bit
    import comparator_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Equal,
    output logic             Bigger,
    output logic             Lower,
    output logic             out_valid
);

    // Cascade node k carries the verdict over bits [WIDTH-1:k]; node WIDTH is the "all equal" seed.
    logic [WIDTH:0] w_gt;
    logic [WIDTH:0] w_lt;
    logic [WIDTH:0] w_eq;
    res_t           w_res;

    res_t r_flags;
    logic r_out_valid;

    assign w_gt[WIDTH] = 1'b0;
    assign w_lt[WIDTH] = 1'b0;
    assign w_eq[WIDTH] = 1'b1;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_chain
        logic w_a;
        logic w_b;

        // A set sign bit means the smaller value, so the MSB cell sees its operands swapped.
        if (SIGNED && (i == WIDTH - 1)) begin : g_sign
            assign w_a = B[i];
            assign w_b = A[i];
        end else begin : g_mag
            assign w_a = A[i];
            assign w_b = B[i];
        end

        comparator_slice u_slice (
            .i_a  (w_a),
            .i_b  (w_b),
            .i_gt (w_gt[i+1]),
            .i_lt (w_lt[i+1]),
            .i_eq (w_eq[i+1]),
            .o_gt (w_gt[i]),
            .o_lt (w_lt[i]),
            .o_eq (w_eq[i])
        );
    end

    assign w_res = pack_flags(w_eq[0], w_gt[0], w_lt[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags     <= RES_NONE;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_flags <= w_res;
            end
        end
    end

    assign {Equal, Bigger, Lower} = r_flags;
    assign out_valid              = r_out_valid;

endmodule

// File: tb/tb_comparator_4bit.sv
// Drives an unsigned and a signed comparator with identical stimulus and checks both
// against an integer-arithmetic reference that tracks held flags across idle cycles.
module tb_comparator_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] A;
    logic [3:0] B;
    logic       eq_u, gt_u, lt_u, ov_u;
    logic       eq_s, gt_s, lt_s, ov_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] exp_u;
    logic [2:0] exp_s;
    logic       exp_ov;

    always #5 clk = ~clk;

    comparator_4bit #(.WIDTH(4), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .Equal(eq_u), .Bigger(gt_u), .Lower(lt_u), .out_valid(ov_u)
    );

    comparator_4bit #(.WIDTH(4), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .Equal(eq_s), .Bigger(gt_s), .Lower(lt_s), .out_valid(ov_s)
    );

    function automatic logic [2:0] ref_flags(input int a, input int b);
        if (a == b) return 3'b100;
        if (a > b)  return 3'b010;
        return 3'b001;
    endfunction

    function automatic int sx(input logic [3:0] v);
        return (int'(v) >= 8) ? int'(v) - 16 : int'(v);
    endfunction

    // Apply one cycle of stimulus and advance the reference to what the outputs should show after it.
    task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b, input logic r);
        in_valid = v;
        A        = a;
        B        = b;
        rst      = r;
        @(posedge clk);
        #1;
        if (r) begin
            exp_u  = 3'b000;
            exp_s  = 3'b000;
            exp_ov = 1'b0;
        end else begin
            exp_ov = v;
            if (v) begin
                exp_u = ref_flags(int'(a), int'(b));
                exp_s = ref_flags(sx(a), sx(b));
            end
        end
    endtask

    task automatic test_reset;
        step(1'b0, 4'h0, 4'h0, 1'b1);
        step(1'b0, 4'h0, 4'h0, 1'b1);
        n_cmp++;
        if ({eq_u, gt_u, lt_u, ov_u} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_u: got %b want 0000", {eq_u, gt_u, lt_u, ov_u});
        end
        n_cmp++;
        if ({eq_s, gt_s, lt_s, ov_s} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_s: got %b want 0000", {eq_s, gt_s, lt_s, ov_s});
        end
        step(1'b0, 4'h9, 4'h2, 1'b0);
        n_cmp++;
        if ({eq_u, gt_u, lt_u, ov_u} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b want 0000", {eq_u, gt_u, lt_u, ov_u});
        end
    endtask

    task automatic test_lower;
        step(1'b1, 4'b0011, 4'b0100, 1'b0);
        n_cmp++;
        if ({eq_u, gt_u, lt_u, ov_u} !== 4'b0011) begin
            n_err++;
            $display("FAIL lower_3_4: got %b want 0011", {eq_u, gt_u, lt_u, ov_u});
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 4'b0101, 4'b0100, 1'b0);
        n_cmp++;
        if ({eq_u, gt_u, lt_u, ov_u} !== 4'b0101) begin
            n_err++;
            $display("FAIL b2b_bigger: got %b want 0101", {eq_u, gt_u, lt_u, ov_u});
        end
        step(1'b1, 4'b0110, 4'b0110, 1'b0);
        n_cmp++;
        if ({eq_u, gt_u, lt_u, ov_u} !== 4'b1001) begin
            n_err++;
            $display("FAIL b2b_equal: got %b want 1001", {eq_u, gt_u, lt_u, ov_u});
        end
    endtask

    task automatic test_boundaries;
        logic [3:0] ta [3];
        logic [3:0] tb [3];
        logic [3:0] te [3];
        ta = '{4'h0, 4'hF, 4'hF};
        tb = '{4'hF, 4'hF, 4'h0};
        te = '{4'b0011, 4'b1001, 4'b0101};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, ta[i], tb[i], 1'b0);
            n_cmp++;
            if ({eq_u, gt_u, lt_u, ov_u} !== te[i]) begin
                n_err++;
                $display("FAIL boundary_%0d: got %b want %b", i, {eq_u, gt_u, lt_u, ov_u}, te[i]);
            end
        end
        step(1'b0, 4'h0, 4'hF, 1'b0);
        n_cmp++;
        if ({eq_u, gt_u, lt_u, ov_u} !== 4'b0100) begin
            n_err++;
            $display("FAIL hold_bigger: got %b want 0100", {eq_u, gt_u, lt_u, ov_u});
        end
    endtask

    task automatic test_signed;
        step(1'b1, 4'b1000, 4'b0111, 1'b0);
        n_cmp++;
        if ({eq_s, gt_s, lt_s, ov_s} !== 4'b0011) begin
            n_err++;
            $display("FAIL signed_m8_p7: got %b want 0011", {eq_s, gt_s, lt_s, ov_s});
        end
        n_cmp++;
        if ({eq_u, gt_u, lt_u, ov_u} !== 4'b0101) begin
            n_err++;
            $display("FAIL unsigned_8_7: got %b want 0101", {eq_u, gt_u, lt_u, ov_u});
        end
        step(1'b1, 4'b1111, 4'b1110, 1'b0);
        n_cmp++;
        if ({eq_s, gt_s, lt_s, ov_s} !== 4'b0101) begin
            n_err++;
            $display("FAIL signed_m1_m2: got %b want 0101", {eq_s, gt_s, lt_s, ov_s});
        end
    endtask

    task automatic test_reset_priority;
        step(1'b1, 4'h9, 4'h2, 1'b1);
        n_cmp++;
        if ({eq_u, gt_u, lt_u, ov_u} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_priority: got %b want 0000", {eq_u, gt_u, lt_u, ov_u});
        end
        step(1'b0, 4'h9, 4'h2, 1'b0);
        n_cmp++;
        if ({eq_s, gt_s, lt_s, ov_s} !== 4'b0000) begin
            n_err++;
            $display("FAIL rst_then_idle: got %b want 0000", {eq_s, gt_s, lt_s, ov_s});
        end
    endtask

    task automatic test_sweep;
        for (int p = 0; p < 256; p++) begin
            step(1'b1, 4'(p >> 4), 4'(p & 15), 1'b0);
            n_cmp++;
            if ({eq_u, gt_u, lt_u, ov_u} !== {exp_u, exp_ov}) begin
                n_err++;
                $display("FAIL sweep_u a=%0d b=%0d: got %b want %b", p >> 4, p & 15,
                         {eq_u, gt_u, lt_u, ov_u}, {exp_u, exp_ov});
            end
            n_cmp++;
            if ({eq_s, gt_s, lt_s, ov_s} !== {exp_s, exp_ov}) begin
                n_err++;
                $display("FAIL sweep_s a=%0d b=%0d: got %b want %b", p >> 4, p & 15,
                         {eq_s, gt_s, lt_s, ov_s}, {exp_s, exp_ov});
            end
            n_cmp++;
            if (!$onehot({eq_u, gt_u, lt_u}) || !$onehot({eq_s, gt_s, lt_s})) begin
                n_err++;
                $display("FAIL onehot p=%0d: got u=%b s=%b want one bit set", p,
                         {eq_u, gt_u, lt_u}, {eq_s, gt_s, lt_s});
            end
        end
    endtask

    task automatic test_random;
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 31) == 0));
            n_cmp++;
            if ({eq_u, gt_u, lt_u, ov_u, eq_s, gt_s, lt_s, ov_s} !==
                {exp_u, exp_ov, exp_s, exp_ov}) begin
                n_err++;
                $display("FAIL random_%0d: got %b want %b", k,
                         {eq_u, gt_u, lt_u, ov_u, eq_s, gt_s, lt_s, ov_s},
                         {exp_u, exp_ov, exp_s, exp_ov});
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = 4'h0;
        B        = 4'h0;
        exp_u    = 3'b000;
        exp_s    = 3'b000;
        exp_ov   = 1'b0;
        test_reset();
        test_lower();
        test_back_to_back();
        test_boundaries();
        test_signed();
        test_reset_priority();
        test_sweep();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
